// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute stage: widths, ALU op and shift
// codes, FSM state encoding and status bit positions.
package alu_exec_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_AND  = 2'b10,
    OP_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4
  } state_e;

  // Bit positions inside the 3-bit status word {V,N,Z}
  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_V = 2;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Command/result bundle of the execute stage. The master drives commands and
// external register writes; the slave (the stage) returns busy/done/result.
// Optional macro ALU_EXEC_ASEL_ZERO_EN adds the asel command field.
interface alu_exec_stage_if;

  logic                               start;
  logic [1:0]                         op;
  logic [1:0]                         shift;
  logic [alu_exec_pkg::REG_AW-1:0]    rn;
  logic [alu_exec_pkg::REG_AW-1:0]    rm;
  logic [alu_exec_pkg::REG_AW-1:0]    rd;
  logic                               wb_en;
`ifdef ALU_EXEC_ASEL_ZERO_EN
  logic                               asel;
`endif
  logic                               ext_we;
  logic [alu_exec_pkg::REG_AW-1:0]    ext_num;
  logic [alu_exec_pkg::DATA_W-1:0]    ext_data;
  logic                               busy;
  logic                               done;
  logic [alu_exec_pkg::DATA_W-1:0]    result;
  logic [2:0]                         status;

  modport master (
    output start, op, shift, rn, rm, rd, wb_en,
`ifdef ALU_EXEC_ASEL_ZERO_EN
    output asel,
`endif
    output ext_we, ext_num, ext_data,
    input  busy, done, result, status
  );

  modport slave (
    input  start, op, shift, rn, rm, rd, wb_en,
`ifdef ALU_EXEC_ASEL_ZERO_EN
    input  asel,
`endif
    input  ext_we, ext_num, ext_data,
    output busy, done, result, status
  );

endinterface

// File: rtl/alu16.sv
// Existing 16-bit ALU: ADD, SUB (A-B), AND, NOT B, with a zero flag.
module alu16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [1:0]  i_op,
  output logic [15:0] o_out,
  output logic        o_z
);

  // Combinational operation select
  always_comb begin
    o_out = 16'h0000;
    case (i_op)
      2'b00:   o_out = i_a + i_b;
      2'b01:   o_out = i_a - i_b;
      2'b10:   o_out = i_a & i_b;
      2'b11:   o_out = ~i_b;
      default: o_out = 16'h0000;
    endcase
  end

  assign o_z = (o_out == 16'h0000);

endmodule

// File: rtl/exec_regfile.sv
// 8 x DATA_W register file: one combinational read port, one synchronous
// write port, synchronous clear on reset.
module exec_regfile
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wnum,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_rnum,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // Register storage: reset clears every entry, otherwise single write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (i_we) begin
      r_mem[i_wnum] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_rnum];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage around alu16: register file, A/B operand registers, B-path
// shifter, C result register and {V,N,Z} status, sequenced by a 5-state FSM
// (IDLE, LOAD_A, LOAD_B, EXEC, WRITE) for one command per start pulse.
// Optional macro ALU_EXEC_ASEL_ZERO_EN: asel=1 forces the ALU A operand to 0.
module alu_exec_stage
  import alu_exec_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  alu_exec_stage_if.slave  bus
);

  state_e            r_state;
  state_e            w_next_state;
  alu_op_e           r_op;
  shift_e            r_shift;
  logic [REG_AW-1:0] r_rn;
  logic [REG_AW-1:0] r_rm;
  logic [REG_AW-1:0] r_rd;
  logic              r_wb_en;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic [2:0]        r_status;
  logic              r_busy;
  logic              r_done;

  logic              w_cmd_accept;
  logic              w_rf_we;
  logic [REG_AW-1:0] w_rf_wnum;
  logic [DATA_W-1:0] w_rf_wdata;
  logic [REG_AW-1:0] w_rf_rnum;
  logic [DATA_W-1:0] w_rf_rdata;
  logic [DATA_W-1:0] w_b_sh;
  logic [DATA_W-1:0] w_a_op;
  logic [DATA_W-1:0] w_alu_out;
  logic              w_alu_z;
  logic              w_v;

  assign w_cmd_accept = (r_state == ST_IDLE) && bus.start;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic: one fixed pass through the sequence per command
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state = ST_LOAD_A;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD_A: w_next_state = ST_LOAD_B;
      ST_LOAD_B: w_next_state = ST_EXEC;
      ST_EXEC:   w_next_state = ST_WRITE;
      ST_WRITE:  w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Registered busy/done, derived from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= (w_next_state == ST_WRITE);
    end
  end

  // Command latch: fields captured only when a start is accepted in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= OP_ADD;
      r_shift <= SH_NONE;
      r_rn    <= {REG_AW{1'b0}};
      r_rm    <= {REG_AW{1'b0}};
      r_rd    <= {REG_AW{1'b0}};
      r_wb_en <= 1'b0;
    end else if (w_cmd_accept) begin
      r_op    <= alu_op_e'(bus.op);
      r_shift <= shift_e'(bus.shift);
      r_rn    <= bus.rn;
      r_rm    <= bus.rm;
      r_rd    <= bus.rd;
      r_wb_en <= bus.wb_en;
    end
  end

  // Register-file port steering: ext writes only in IDLE, write-back in WRITE
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_wnum  = {REG_AW{1'b0}};
    w_rf_wdata = {DATA_W{1'b0}};
    if ((r_state == ST_IDLE) && bus.ext_we) begin
      w_rf_we    = 1'b1;
      w_rf_wnum  = bus.ext_num;
      w_rf_wdata = bus.ext_data;
    end else if ((r_state == ST_WRITE) && r_wb_en) begin
      w_rf_we    = 1'b1;
      w_rf_wnum  = r_rd;
      w_rf_wdata = r_c;
    end else begin
      w_rf_we    = 1'b0;
    end
  end

  assign w_rf_rnum = (r_state == ST_LOAD_B) ? r_rm : r_rn;

  exec_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_rf_we),
    .i_wnum  (w_rf_wnum),
    .i_wdata (w_rf_wdata),
    .i_rnum  (w_rf_rnum),
    .o_rdata (w_rf_rdata)
  );

  // Operand registers: A in LOAD_A, B in LOAD_B
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= {DATA_W{1'b0}};
      r_b <= {DATA_W{1'b0}};
    end else begin
      if (r_state == ST_LOAD_A) begin
        r_a <= w_rf_rdata;
      end
      if (r_state == ST_LOAD_B) begin
        r_b <= w_rf_rdata;
      end
    end
  end

  // B-path shifter: single-bit shifts, ASR replicates the sign bit
  always_comb begin
    w_b_sh = r_b;
    case (r_shift)
      SH_NONE: w_b_sh = r_b;
      SH_LSL:  w_b_sh = {r_b[DATA_W-2:0], 1'b0};
      SH_LSR:  w_b_sh = {1'b0, r_b[DATA_W-1:1]};
      SH_ASR:  w_b_sh = {r_b[DATA_W-1], r_b[DATA_W-1:1]};
      default: w_b_sh = r_b;
    endcase
  end

`ifdef ALU_EXEC_ASEL_ZERO_EN
  logic r_asel;

  // asel latched alongside the rest of the command
  always_ff @(posedge clk) begin
    if (reset) begin
      r_asel <= 1'b0;
    end else if (w_cmd_accept) begin
      r_asel <= bus.asel;
    end
  end

  assign w_a_op = r_asel ? {DATA_W{1'b0}} : r_a;
`else
  assign w_a_op = r_a;
`endif

  alu16 u_alu (
    .i_a   (w_a_op),
    .i_b   (w_b_sh),
    .i_op  (r_op),
    .o_out (w_alu_out),
    .o_z   (w_alu_z)
  );

  // Signed overflow: only meaningful for ADD/SUB, judged on the ALU operands
  always_comb begin
    w_v = 1'b0;
    case (r_op)
      OP_ADD:  w_v = (w_a_op[DATA_W-1] == w_b_sh[DATA_W-1]) &&
                     (w_alu_out[DATA_W-1] != w_a_op[DATA_W-1]);
      OP_SUB:  w_v = (w_a_op[DATA_W-1] != w_b_sh[DATA_W-1]) &&
                     (w_alu_out[DATA_W-1] != w_a_op[DATA_W-1]);
      default: w_v = 1'b0;
    endcase
  end

  // Result and status registers update only in EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c      <= {DATA_W{1'b0}};
      r_status <= 3'b000;
    end else if (r_state == ST_EXEC) begin
      r_c              <= w_alu_out;
      r_status[STAT_Z] <= w_alu_z;
      r_status[STAT_N] <= w_alu_out[DATA_W-1];
      r_status[STAT_V] <= w_v;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_c;
  assign bus.status = r_status;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, hand-written
// protocol sequences, and random commands against a behavioural model.
module tb_alu_exec_stage;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] m_reg [8];

  alu_exec_stage_if bus_if ();

  alu_exec_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w0;
    logic [2:0]  n0;
    logic [15:0] d0;
    logic        w1;
    logic [2:0]  n1;
    logic [15:0] d1;
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [2:0]  rd;
    logic        wb;
    logic [15:0] exp_res;
    logic [2:0]  exp_st;
    logic [2:0]  chk_num;
    logic [15:0] chk_val;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: B shift, then two's-complement arithmetic with range test for V
  function automatic void model_alu(input logic [15:0] a, input logic [15:0] b,
                                    input logic [1:0] op, input logic [1:0] sh,
                                    output logic [15:0] res, output logic [2:0] st);
    logic [15:0] bs;
    int          s;
    logic        v;
    case (sh)
      2'd1:    bs = b * 2;
      2'd2:    bs = b / 2;
      2'd3:    bs = (b / 2) + ((b >= 16'h8000) ? 16'h8000 : 16'h0000);
      default: bs = b;
    endcase
    v = 1'b0;
    s = 0;
    case (op)
      2'd0: begin
        s   = int'($signed(a)) + int'($signed(bs));
        res = s[15:0];
        v   = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        s   = int'($signed(a)) - int'($signed(bs));
        res = s[15:0];
        v   = (s > 32767) || (s < -32768);
      end
      2'd2:    res = a & bs;
      default: res = ~bs;
    endcase
    st = {v, res[15], (res == 16'h0000)};
  endfunction

  task automatic ext_write(input logic [2:0] n, input logic [15:0] d);
    bus_if.ext_we   = 1'b1;
    bus_if.ext_num  = n;
    bus_if.ext_data = d;
    tick();
    bus_if.ext_we   = 1'b0;
    m_reg[n] = d;
  endtask

  // Issue one command from IDLE (optionally with a same-cycle ext write),
  // wait for done with a bound, compare against the model, return to IDLE.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] sh,
                         input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                         input logic wb, input logic xwe, input logic [2:0] xnum,
                         input logic [15:0] xdata, input string tag);
    int          edges;
    logic [15:0] eres;
    logic [2:0]  est;
    bus_if.start    = 1'b1;
    bus_if.op       = op;
    bus_if.shift    = sh;
    bus_if.rn       = rn;
    bus_if.rm       = rm;
    bus_if.rd       = rd;
    bus_if.wb_en    = wb;
    bus_if.ext_we   = xwe;
    bus_if.ext_num  = xnum;
    bus_if.ext_data = xdata;
    if (xwe) m_reg[xnum] = xdata;
    model_alu(m_reg[rn], m_reg[rm], op, sh, eres, est);
    tick();
    bus_if.start  = 1'b0;
    bus_if.ext_we = 1'b0;
    edges = 1;
    while (!bus_if.done && edges < 20) begin
      tick();
      edges++;
    end
    check({tag, "_latency"}, edges, 4);
    check({tag, "_busy_in_write"}, {31'd0, bus_if.busy}, 32'd1);
    check({tag, "_result"}, {16'd0, bus_if.result}, {16'd0, eres});
    check({tag, "_status"}, {29'd0, bus_if.status}, {29'd0, est});
    if (wb) m_reg[rd] = eres;
    tick();
    check({tag, "_done_pulse"}, {31'd0, bus_if.done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, bus_if.busy}, 32'd0);
  endtask

  // Read a register through NOT B (compare only): ~result must equal exp
  task automatic peek(input logic [2:0] r, input logic [15:0] exp, input string tag);
    logic [15:0] got;
    run_cmd(2'd3, 2'd0, 3'd0, r, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, "peek");
    got = ~bus_if.result;
    check(tag, {16'd0, got}, {16'd0, exp});
  endtask

  initial begin
    int          ndone;
    logic [15:0] eres;
    logic [2:0]  est;
    logic [2:0]  rr;

    vecs[0] = '{1'b1, 3'd0, 16'd1378, 1'b1, 3'd1, 16'd22562, 2'd0, 2'd0, 3'd0, 3'd1, 3'd2, 1'b1,
                16'h5D84, 3'b000, 3'd2, 16'h5D84};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 2'd1, 2'd0, 3'd0, 3'd1, 3'd3, 1'b1,
                16'hAD40, 3'b010, 3'd3, 16'hAD40};
    vecs[2] = '{1'b1, 3'd4, 16'h7FFF, 1'b1, 3'd5, 16'h0001, 2'd0, 2'd0, 3'd4, 3'd5, 3'd4, 1'b1,
                16'h8000, 3'b110, 3'd4, 16'h8000};
    vecs[3] = '{1'b1, 3'd5, 16'h8002, 1'b0, 3'd0, 16'h0000, 2'd3, 2'd3, 3'd4, 3'd5, 3'd5, 1'b1,
                16'h3FFE, 3'b000, 3'd5, 16'h3FFE};
    vecs[4] = '{1'b1, 3'd6, 16'h00F0, 1'b1, 3'd7, 16'h0F00, 2'd2, 2'd0, 3'd6, 3'd7, 3'd6, 1'b0,
                16'h0000, 3'b001, 3'd6, 16'h00F0};

    bus_if.start    = 1'b0;
    bus_if.op       = 2'd0;
    bus_if.shift    = 2'd0;
    bus_if.rn       = 3'd0;
    bus_if.rm       = 3'd0;
    bus_if.rd       = 3'd0;
    bus_if.wb_en    = 1'b0;
    bus_if.ext_we   = 1'b0;
    bus_if.ext_num  = 3'd0;
    bus_if.ext_data = 16'h0000;
`ifdef ALU_EXEC_ASEL_ZERO_EN
    bus_if.asel     = 1'b0;
`endif
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;

    reset = 1'b1;
    tick();
    tick();
    check("rst_busy",   {31'd0, bus_if.busy}, 32'd0);
    check("rst_done",   {31'd0, bus_if.done}, 32'd0);
    check("rst_result", {16'd0, bus_if.result}, 32'd0);
    check("rst_status", {29'd0, bus_if.status}, 32'd0);
    reset = 1'b0;
    tick();

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].w0) ext_write(vecs[i].n0, vecs[i].d0);
      if (vecs[i].w1) ext_write(vecs[i].n1, vecs[i].d1);
      run_cmd(vecs[i].op, vecs[i].sh, vecs[i].rn, vecs[i].rm, vecs[i].rd, vecs[i].wb,
              1'b0, 3'd0, 16'h0000, "vec");
      check("vec_tbl_result", {16'd0, bus_if.result}, {16'd0, vecs[i].exp_res});
      check("vec_tbl_status", {29'd0, bus_if.status}, {29'd0, vecs[i].exp_st});
      peek(vecs[i].chk_num, vecs[i].chk_val, "vec_tbl_reg");
    end

    // start pulsed during LOAD_B must be ignored
    ext_write(3'd0, 16'h0100);
    ext_write(3'd1, 16'h0023);
    ext_write(3'd6, 16'h5555);
    model_alu(m_reg[0], m_reg[1], 2'd0, 2'd0, eres, est);
    bus_if.start = 1'b1; bus_if.op = 2'd0; bus_if.shift = 2'd0;
    bus_if.rn = 3'd0; bus_if.rm = 3'd1; bus_if.rd = 3'd7; bus_if.wb_en = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    bus_if.start = 1'b1; bus_if.op = 2'd3; bus_if.rd = 3'd6;
    tick();
    bus_if.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.done) begin
        ndone++;
        check("lb_result", {16'd0, bus_if.result}, {16'd0, eres});
      end
      tick();
    end
    check("lb_done_count", ndone, 1);
    m_reg[7] = eres;
    peek(3'd7, 16'h0123, "lb_r7");
    peek(3'd6, 16'h5555, "lb_r6_untouched");

    // ext_we during EXEC must be ignored
    ext_write(3'd3, 16'h0F0F);
    bus_if.start = 1'b1; bus_if.op = 2'd2; bus_if.shift = 2'd0;
    bus_if.rn = 3'd2; bus_if.rm = 3'd3; bus_if.rd = 3'd0; bus_if.wb_en = 1'b0;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    bus_if.ext_we = 1'b1; bus_if.ext_num = 3'd3; bus_if.ext_data = 16'hDEAD;
    tick();
    bus_if.ext_we = 1'b0;
    check("exec_ext_done", {31'd0, bus_if.done}, 32'd1);
    tick();
    peek(3'd3, 16'h0F0F, "exec_ext_ignored");

    // ext_we with start in the same IDLE cycle: new value is used
    run_cmd(2'd0, 2'd0, 3'd1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd1, 16'h1234, "ext_start");
    check("ext_start_value", {16'd0, bus_if.result}, 32'h0000_2468);

    // Aliasing rn==rm==rd: reads see the old value
    ext_write(3'd4, 16'h0005);
    run_cmd(2'd0, 2'd1, 3'd4, 3'd4, 3'd4, 1'b1, 1'b0, 3'd0, 16'h0000, "alias");
    check("alias_value", {16'd0, bus_if.result}, 32'h0000_000F);

    // Randomized commands against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) ext_write(3'($urandom_range(0, 7)), 16'($urandom));
      run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 16'($urandom), "rnd");
    end
    for (int i = 0; i < 8; i++) begin
      rr = 3'(i);
      peek(rr, m_reg[i], "rnd_reg");
    end

    // Reset asserted in the EXEC cycle
    ext_write(3'd0, 16'h1111);
    ext_write(3'd1, 16'h2222);
    bus_if.start = 1'b1; bus_if.op = 2'd0; bus_if.shift = 2'd0;
    bus_if.rn = 3'd0; bus_if.rm = 3'd1; bus_if.rd = 3'd2; bus_if.wb_en = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    check("mid_in_exec_busy", {31'd0, bus_if.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy",   {31'd0, bus_if.busy}, 32'd0);
    check("mid_rst_done",   {31'd0, bus_if.done}, 32'd0);
    check("mid_rst_result", {16'd0, bus_if.result}, 32'd0);
    check("mid_rst_status", {29'd0, bus_if.status}, 32'd0);
    tick();
    check("mid_rst_no_done", {31'd0, bus_if.done}, 32'd0);
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      rr = 3'(i);
      peek(rr, 16'h0000, "mid_rst_reg");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execute stage wrapped around the existing 16-bit ALU (ops ADD/SUB/AND/NOT B, Z flag).
- Owns an 8x16 register file with one read and one write port, the A/B operand registers, and a B-path shifter.
- Owns the C result register and the Z/N/V status register.
- A multi-cycle FSM sequences operand fetch, execute and write-back for one command per start pulse.

Parameters:
- DATA_W, 16, datapath width. Only 16 is supported, to match the ALU.
- REG_AW, 3, register-number width (8 registers).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  command valid; sampled only in IDLE
- op  input  2  ALUop: 00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B
- shift  input  2  B shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
- rn  input  REG_AW  A-source register
- rm  input  REG_AW  B-source register
- rd  input  REG_AW  destination register
- wb_en  input  1  1 = write C to rd; 0 = compare only
- ext_we  input  1  external register-file write enable
- ext_num  input  REG_AW  external write register
- ext_data  input  DATA_W  external write data
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse in the WRITE state
- result  output  DATA_W  C register
- status  output  3  {V,N,Z}

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE. A, B, C, status and all 8 registers clear to 0. busy and done are 0. This applies in any state, including mid-command; no write-back occurs in that cycle.
- FSM states: IDLE -> LOAD_A -> LOAD_B -> EXEC -> WRITE -> IDLE. The encoding is a package constant.
- Command acceptance: in IDLE with start=1, op/shift/rn/rm/rd/wb_en are latched and the next state is LOAD_A. In any other state start is ignored and no command is queued.
- LOAD_A: A <= R[rn].
- LOAD_B: B <= R[rm].
- EXEC:
  - C <= ALU(A, shift(B), op).
  - Z = (C==0).
  - N = C[15].
  - V = signed overflow for ADD/SUB: ADD when A[15]==Bs[15] and out[15]!=A[15]; SUB when A[15]!=Bs[15] and out[15]!=A[15]. V = 0 for AND/NOT.
  - Status changes only in EXEC; it holds otherwise.
- WRITE: if wb_en, R[rd] <= C. done=1 for exactly this cycle.
- Latency: start sampled at edge 0 -> done high in the cycle after edge 3. result is valid from the EXEC edge onward. Minimum command spacing is 5 cycles.
- Arithmetic: modulo 2^16. All shifts are by 1 bit. ASR1 replicates bit 15.
- External write:
  - Honoured only in IDLE; ignored while busy.
  - If ext_we and start arrive in the same IDLE cycle, the write lands first, so LOAD_A/LOAD_B read the new value.
- Register aliasing: rn==rm==rd is legal. Reads happen before write-back, so the old value is used.

Optional Feature:
- Macro: ALU_EXEC_ASEL_ZERO_EN.
- Defined: adds input port asel (1 bit), latched with the command. asel=1 forces the ALU A operand to 0, so ADD gives MOV Rd, Rm{shift}. LOAD_A still executes and the cycle count is unchanged.
- Undefined: no asel port; A always comes from R[rn].

Decomposition:
- Package alu_exec_pkg:
  - DATA_W, REG_AW
  - ALUop codes: OP_ADD, OP_SUB, OP_AND, OP_NOTB
  - shift codes: SH_NONE, SH_LSL, SH_LSR, SH_ASR
  - FSM state type/encoding
  - status bit indices: Z=0, N=1, V=2
- Sub-module exec_regfile: 8xDATA_W, one combinational read port, one synchronous write port, synchronous reset clear.
- The existing ALU is instantiated unchanged.
- Shifter and V logic stay inline.

Test Plan:
- ADD: ext-write R0=16'd1378, R1=16'd22562; start op=00 rn=0 rm=1 rd=2 shift=00 wb_en=1 -> done 4 cycles after start; result=R2=16'h5D84; status=3'b000.
- SUB: same R0/R1, op=01 rd=3 -> result=16'hAD40; status {V,N,Z}=3'b010; R3=16'hAD40.
- Overflow plus shift:
  - R4=16'h7FFF, R5=16'h0001; ADD rn=4 rm=5 -> result=16'h8000, status=3'b110.
  - R5=16'h8002; op=11 shift=11 -> result=16'h3FFE (ASR gives C001, then NOT).
- Compare-only and Z:
  - R6=16'h00F0, R7=16'h0F00; AND wb_en=0 rd=6 -> result=0; status=3'b001; R6 still 16'h00F0.
- Protocol:
  - start pulsed during LOAD_B is ignored: one done only.
  - ext_we during EXEC is ignored: the register is unchanged.
  - ext_we together with start in IDLE: the new value is used.
- Reset mid-op: assert reset in the EXEC cycle -> next cycle state=IDLE, busy=0, done=0, result=0, status=0, no write to rd, all registers read 0.
